// File: rtl/synth_slot_scheduler_if.sv
// Bundles the scheduler's control inputs and slot-sequencing outputs.
// master is the scheduler side and slave is the requester/consumer side.
interface synth_slot_scheduler_if #(
  parameter int unsigned V_WIDTH  = 3,
  parameter int unsigned E_WIDTH  = 3,
  parameter int unsigned PH_WIDTH = 2
);
  logic                       trig;
  logic                       enable;
  logic                       cfg_req;
  logic                       clear_ovr;
  logic                       cfg_gnt;
  logic [V_WIDTH+E_WIDTH-1:0] xxxx;
  logic [PH_WIDTH-1:0]        slot_phase;
  logic                       slot_valid;
  logic                       osc_slot;
  logic                       frame_start;
  logic                       frame_done;
  logic                       busy;
  logic                       overrun;
  logic [7:0]                 overrun_cnt;

  modport master (
    input  trig, enable, cfg_req, clear_ovr,
    output cfg_gnt, xxxx, slot_phase, slot_valid, osc_slot,
    output frame_start, frame_done, busy, overrun, overrun_cnt
  );

  modport slave (
    output trig, enable, cfg_req, clear_ovr,
    input  cfg_gnt, xxxx, slot_phase, slot_valid, osc_slot,
    input  frame_start, frame_done, busy, overrun, overrun_cnt
  );
endinterface

// File: rtl/synth_slot_scheduler.sv
// Per-sample frame sequencer: walks every voice/envelope slot on each trig rise, grants the
// config path between frames, and counts sample ticks that arrive while it cannot start a frame.
module synth_slot_scheduler #(
  parameter int unsigned VOICES      = 8,
  parameter int unsigned V_OSC       = 4,
  parameter int unsigned V_WIDTH     = 3,
  parameter int unsigned E_WIDTH     = 3,
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                    AUDIO_CLK,
  input logic                    reset_reg_N,
  synth_slot_scheduler_if.master sched_if
);
  localparam int unsigned PhW   = $clog2(SLOT_CYCLES);
  localparam int unsigned SlotW = V_WIDTH + E_WIDTH;

  localparam logic [SlotW-1:0]   LastSlot  = SlotW'(VOICES * 2 * V_OSC - 1);
  localparam logic [PhW-1:0]     LastPhase = PhW'(SLOT_CYCLES - 1);
  localparam logic [E_WIDTH-1:0] OscLimit  = E_WIDTH'(V_OSC);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StCfg  = 2'd2;

  logic [SYNC_STAGES-1:0] trig_sync_q, trig_sync_d;
  logic                   trig_prev_q, trig_prev_d;
  logic [1:0]             state_q, state_d;
  logic [SlotW-1:0]       slot_q, slot_d;
  logic [PhW-1:0]         phase_q, phase_d;
  logic                   pending_q, pending_d;
  logic                   frame_start_q, frame_start_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overrun_q, overrun_d;
  logic [7:0]             ovr_cnt_q, ovr_cnt_d;
  logic                   rise;
  logic                   ovr_event;

  // The chain resets to all ones so a trig already high at reset release never looks like a rise.
  always_comb begin
    trig_sync_d = {trig_sync_q[SYNC_STAGES-2:0], sched_if.trig};
    trig_prev_d = trig_sync_q[SYNC_STAGES-1];
    rise        = trig_sync_q[SYNC_STAGES-1] & ~trig_prev_q & sched_if.enable;
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    phase_d       = phase_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    ovr_event     = 1'b0;
    case (state_q)
      StIdle: begin
        if (rise || (pending_q && sched_if.enable)) begin
          state_d       = StRun;
          pending_d     = 1'b0;
          frame_start_d = 1'b1;
          slot_d        = '0;
          phase_d       = '0;
        end else if (sched_if.cfg_req) begin
          state_d = StCfg;
        end
      end
      StRun: begin
        ovr_event = rise;
        phase_d   = phase_q + 1'b1;
        if (phase_q == LastPhase) begin
          if (slot_q == LastSlot) begin
            state_d      = StIdle;
            slot_d       = '0;
            phase_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      StCfg: begin
        // One-deep pending: a second tick during the grant is dropped.
        if (rise) begin
          if (pending_q) begin
            ovr_event = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (!sched_if.cfg_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_event) begin
      overrun_d = 1'b1;
      if (sched_if.clear_ovr) begin
        ovr_cnt_d = 8'd1;
      end else if (ovr_cnt_q != 8'hff) begin
        ovr_cnt_d = ovr_cnt_q + 8'd1;
      end
    end else if (sched_if.clear_ovr) begin
      overrun_d = 1'b0;
      ovr_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      trig_sync_q   <= '1;
      trig_prev_q   <= 1'b1;
      state_q       <= StIdle;
      slot_q        <= '0;
      phase_q       <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= 8'd0;
    end else begin
      trig_sync_q   <= trig_sync_d;
      trig_prev_q   <= trig_prev_d;
      state_q       <= state_d;
      slot_q        <= slot_d;
      phase_q       <= phase_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      ovr_cnt_q     <= ovr_cnt_d;
    end
  end

  always_comb begin
    sched_if.busy        = (state_q == StRun);
    sched_if.slot_valid  = (state_q == StRun);
    sched_if.cfg_gnt     = (state_q == StCfg);
    sched_if.xxxx        = slot_q;
    sched_if.slot_phase  = phase_q;
    sched_if.osc_slot    = (state_q == StRun) && (slot_q[E_WIDTH-1:0] < OscLimit);
    sched_if.frame_start = frame_start_q;
    sched_if.frame_done  = frame_done_q;
    sched_if.overrun     = overrun_q;
    sched_if.overrun_cnt = ovr_cnt_q;
  end
endmodule
